// File: rtl/pt5_frame_hydrator.sv
// Fetches a frame of 32-bit words from memory and unpacks every byte as five balanced trits.
// One read in flight at a time; beats leave on a valid/ready stream with trit 0 in bits [1:0].
module pt5_frame_hydrator #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [DEPTH_W-1:0] frame_depth,
  output logic               mem_rd_req,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic               mem_rd_gnt,
  input  logic               mem_rd_valid,
  input  logic [31:0]        mem_rd_data,
  output logic               trit_valid,
  input  logic               trit_ready,
  output logic [9:0]         trit_data,
  output logic               trit_last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, FIN} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] cnt_q;
  logic [1:0]         idx_q;
  logic [31:0]        word_q;
  logic               err_q;

  logic [7:0]         cur_byte;
  logic               byte_bad;
  logic               last_word;
  logic [ADDR_W-1:0]  addr_d;

  // Base-3 digit d maps to trit d-1: 0 -> 2'b11 (-1), 1 -> 2'b00 (0), 2 -> 2'b01 (+1).
  function automatic logic [9:0] pt5_decode(input logic [7:0] v);
    logic [7:0] t;
    logic [9:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      case (t % 8'd3)
        8'd0:    r[2*i +: 2] = 2'b11;
        8'd1:    r[2*i +: 2] = 2'b00;
        default: r[2*i +: 2] = 2'b01;
      endcase
      t = t / 8'd3;
    end
    return r;
  endfunction

  assign cur_byte  = word_q[{idx_q, 3'b000} +: 8];
  assign byte_bad  = (cur_byte > 8'd242);
  assign last_word = (cnt_q == depth_q - DEPTH_W'(1));
  assign addr_d    = addr_q + ADDR_W'(4);

  assign mem_rd_req  = (state_q == REQ);
  assign mem_rd_addr = addr_q;
  assign trit_valid  = (state_q == EMIT);
  assign trit_data   = (trit_valid && !byte_bad) ? pt5_decode(cur_byte) : 10'd0;
  assign trit_last   = trit_valid && (idx_q == 2'd3) && last_word;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign err         = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      depth_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= base_addr & ~ADDR_W'(3);
            depth_q <= frame_depth;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            state_q <= (frame_depth == '0) ? FIN : REQ;
          end
        end
        REQ: begin
          if (mem_rd_gnt) state_q <= WAIT;
        end
        WAIT: begin
          if (mem_rd_valid) begin
            word_q  <= mem_rd_data;
            idx_q   <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (trit_ready) begin
            if (byte_bad) err_q <= 1'b1;
            if (idx_q != 2'd3) begin
              idx_q <= idx_q + 2'd1;
            end else begin
              cnt_q   <= cnt_q + DEPTH_W'(1);
              addr_q  <= addr_d;
              state_q <= last_word ? FIN : REQ;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pt5_frame_hydrator.sv
// Directed bench for pt5_frame_hydrator: a simple memory responder plus hand-decoded beat tables.
module tb_pt5_frame_hydrator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] frame_depth;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        trit_valid;
  logic        trit_ready;
  logic [9:0]  trit_data;
  logic        trit_last;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] words [4];
  logic [9:0]  beats [16];

  always #5 clk = ~clk;

  pt5_frame_hydrator dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .frame_depth(frame_depth), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_gnt(mem_rd_gnt), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .trit_valid(trit_valid), .trit_ready(trit_ready), .trit_data(trit_data),
    .trit_last(trit_last), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from IDLE, serving reads after gnt_dly refused cycles and vld_dly cycles of latency.
  task automatic run_frame(input logic [31:0] base, input int depth, input int gnt_dly,
                           input int vld_dly, input int rdy_mode, input bit extra_start,
                           input logic exp_err);
    logic [31:0] base_al;
    int   ngnt, nbeat, ndone, vcnt, rw, c;
    bit   pending, held_vld, rdy;
    logic [9:0] held;
    base_al = base & 32'hFFFF_FFFC;
    ngnt = 0; nbeat = 0; ndone = 0; vcnt = 0; rw = 0;
    pending = 0; held_vld = 0; held = '0;
    base_addr = base; frame_depth = depth; start = 1'b1;
    for (c = 1; c <= 600 && ndone == 0; c++) begin
      @(negedge clk);
      start = 1'b0; mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
      if (extra_start && c == 4) begin
        start = 1'b1; base_addr = 32'h100; frame_depth = 7;
      end
      if (c == 1) begin
        chk("req_latency", mem_rd_req, depth != 0);
        if (depth == 0) chk("depth0_done_latency", done, 1);
      end
      if (pending) begin
        vcnt++;
        if (vcnt == vld_dly) begin
          mem_rd_valid = 1'b1; mem_rd_data = words[ngnt-1]; pending = 0;
        end
      end
      if (mem_rd_req) begin
        chk("rd_addr", mem_rd_addr, base_al + 32'(4 * ngnt));
        if (rw == gnt_dly) begin
          mem_rd_gnt = 1'b1; ngnt++; rw = 0; pending = 1; vcnt = 0;
        end else rw++;
      end
      rdy = (rdy_mode == 0) ? 1'b1 : c[0];
      trit_ready = rdy;
      if (trit_valid) begin
        if (held_vld) chk("stall_stable", trit_data, held);
        if (rdy && nbeat < 16) begin
          chk("beat", trit_data, beats[nbeat]);
          chk("last", trit_last, nbeat == 4 * depth - 1);
          nbeat++;
        end
      end
      held_vld = trit_valid && !rdy;
      held = trit_data;
      if (done) begin
        ndone++;
        chk("beats_at_done", nbeat, 4 * depth);
        if (rdy_mode == 0) chk("frame_cycles", c, depth * (gnt_dly + vld_dly + 5) + 1);
      end
    end
    chk("done_seen", ndone, 1);
    chk("gnt_count", ngnt, depth);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("busy_after", busy, 0);
    chk("err", err, exp_err);
  endtask

  initial begin
    int acc;
    reset = 1'b1; start = 0; base_addr = 0; frame_depth = 0;
    mem_rd_gnt = 0; mem_rd_valid = 0; mem_rd_data = 0; trit_ready = 0;
    #1;
    chk("rst_outputs", {mem_rd_req, trit_valid, trit_last, busy, done, err}, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_data", trit_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset while a beat is stalled, then a stray read return.
    @(negedge clk);
    base_addr = 32'h40; frame_depth = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_req", mem_rd_req, 1);
    mem_rd_gnt = 1'b1;
    @(negedge clk);
    mem_rd_gnt = 1'b0;
    chk("t1_req_drop", mem_rd_req, 0);
    mem_rd_valid = 1'b1; mem_rd_data = 32'h7979_7979;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    chk("t1_valid", trit_valid, 1);
    chk("t1_data", trit_data, 10'h000);
    @(negedge clk);
    chk("t1_stalled", trit_valid, 1);
    reset = 1'b1;
    #1;
    chk("t1_rst_outputs", {mem_rd_req, trit_valid, trit_last, busy, done, err}, 0);
    chk("t1_rst_data", trit_data, 0);
    chk("t1_rst_addr", mem_rd_addr, 0);
    @(negedge clk);
    reset = 1'b0; trit_ready = 1'b1;
    mem_rd_valid = 1'b1; mem_rd_data = 32'h0000_0000;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      acc += int'(trit_valid) + int'(done) + int'(busy) + int'(mem_rd_req);
    end
    chk("t1_quiet_after_reset", acc, 0);

    // Basic single-word decode.
    words[0] = 32'hF279_0079;
    beats[0] = 10'h000; beats[1] = 10'h3FF; beats[2] = 10'h000; beats[3] = 10'h155;
    run_frame(32'h0, 1, 0, 2, 0, 0, 1'b0);

    // Unaligned base, slow grant, throttled consumer.
    words[0] = 32'h00F2_0079; words[1] = 32'h0A05_0201; words[2] = 32'h0903_1B51;
    beats[0] = 10'h000; beats[1]  = 10'h3FF; beats[2]  = 10'h155; beats[3]  = 10'h3FF;
    beats[4] = 10'h3FC; beats[5]  = 10'h3FD; beats[6]  = 10'h3F1; beats[7]  = 10'h3CC;
    beats[8] = 10'h0FF; beats[9]  = 10'h33F; beats[10] = 10'h3F3; beats[11] = 10'h3CF;
    run_frame(32'h13, 3, 3, 1, 1, 0, 1'b0);

    // Empty frame.
    run_frame(32'h80, 0, 0, 1, 0, 0, 1'b0);

    // Invalid byte sets the sticky error.
    words[0] = 32'h0000_FF05;
    beats[0] = 10'h3F1; beats[1] = 10'h000; beats[2] = 10'h3FF; beats[3] = 10'h3FF;
    run_frame(32'h200, 1, 1, 1, 0, 0, 1'b1);

    // Address wrap, stray start while busy, error cleared by the new start.
    words[0] = 32'h00F2_0079; words[1] = 32'h0A05_0201;
    beats[0] = 10'h000; beats[1] = 10'h3FF; beats[2] = 10'h155; beats[3] = 10'h3FF;
    beats[4] = 10'h3FC; beats[5] = 10'h3FD; beats[6] = 10'h3F1; beats[7] = 10'h3CC;
    run_frame(32'hFFFF_FFFC, 2, 0, 1, 0, 1, 1'b0);
    chk("t6_final_addr", mem_rd_addr, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
